// File: rtl/aes_dec_iter_ctrl.sv
// Iterative AES-128 decryption engine: one inverse round per clock over a single
// 128-bit state register, with round keys fetched from an external store by index.
module aes_dec_iter_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_in,
    input  logic         rk_valid,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_e;

    // FIPS-197 inverse S-box, entry 0 in the most significant byte
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    state_e       st_q, st_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] data_q, data_d;
    logic [127:0] sr, sb, ark, mixed;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] imc_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xt(a[i]);
            x4[i] = xt(x2[i]);
            x8[i] = xt(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Byte k = 4c + r sits at [127-8k -: 8]; row r rotates right by r columns
    always_comb begin
        sr = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[127-8*(4*c+r) -: 8] = data_q[127-8*(4*((c-r)&3)+r) -: 8];
    end

    always_comb begin
        sb = '0;
        for (int k = 0; k < 16; k++)
            sb[127-8*k -: 8] = INV_SBOX[sr[127-8*k -: 8]];
    end

    assign ark = sb ^ rk_in;

    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++)
            mixed[127-32*c -: 32] = imc_col(ark[127-32*c -: 32]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= IDLE;
            rnd_q  <= 4'd9;
            data_q <= '0;
        end else begin
            st_q   <= st_d;
            rnd_q  <= rnd_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        rnd_d  = rnd_q;
        data_d = data_q;
        case (st_q)
            IDLE: begin
                if (in_valid && rk_valid) begin
                    data_d = in_data ^ rk_in;
                    rnd_d  = 4'd9;
                    st_d   = ROUND;
                end
            end
            ROUND: begin
                if (rnd_q > 4'd9) begin
                    st_d = IDLE;
                end else if (rk_valid) begin
                    if (rnd_q == 4'd0) begin
                        data_d = ark;
                        st_d   = DONE;
                    end else begin
                        data_d = mixed;
                        rnd_d  = rnd_q - 4'd1;
                    end
                end
            end
            DONE: begin
                if (out_ready) st_d = IDLE;
            end
            default: st_d = IDLE;
        endcase
    end

    // rk_idx depends only on state and rnd so the key store never sees a comb loop
    always_comb begin
        in_ready  = (st_q == IDLE) && !rst;
        out_valid = (st_q == DONE);
        busy      = (st_q != IDLE);
        out_data  = data_q;
        case (st_q)
            ROUND:   rk_idx = rnd_q;
            DONE:    rk_idx = 4'd0;
            default: rk_idx = 4'd10;
        endcase
    end

endmodule

// File: tb/tb_aes_dec_iter_ctrl.sv
// Directed bench for aes_dec_iter_ctrl: FIPS-197 vectors, stalls, reset, back-to-back.
module tb_aes_dec_iter_ctrl;

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, rk_valid, out_valid, out_ready, busy;
    logic [127:0] in_data, rk_in, out_data;
    logic [3:0]   rk_idx;
    logic         key_sel;
    logic [7:0]   fsbox [256];
    logic [127:0] rk_tab [2][11];
    int           tests = 0;
    int           fails = 0;

    always #5 clk = ~clk;

    aes_dec_iter_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rk_idx(rk_idx), .rk_in(rk_in), .rk_valid(rk_valid), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    // Key store model: round key for the requested index, same cycle
    always_comb begin
        rk_in = '0;
        if (rk_idx <= 4'd10) rk_in = rk_tab[key_sel][rk_idx];
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Forward S-box from GF(2^8) inverse plus affine map
    task automatic build_sbox();
        logic [7:0] inv, xb, yb;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            xb  = 8'(x);
            for (int y = 1; y < 256; y++) begin
                yb = 8'(y);
                if (gmul(xb, yb) == 8'h01) inv = yb;
            end
            fsbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                       {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand(input int k, input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {fsbox[t[31:24]], fsbox[t[23:16]], fsbox[t[15:8]], fsbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_tab[k][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Called at a negedge in IDLE; accepts one block and drains it
    task automatic run_block(input logic [127:0] ct, input logic [127:0] pt, input int stall_idx,
                             input int stall_n, input int ready_wait, input int exp_lat,
                             input bit garbage, input string tag);
        int lat, stall_left;
        bit stalled;
        stall_left = stall_n;
        out_ready  = (ready_wait == 0);
        in_data    = ct;
        in_valid   = 1'b1;
        rk_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, " busy after accept"}, busy, 1);
        chk({tag, " in_ready after accept"}, in_ready, 0);
        chk({tag, " rk_idx first round"}, rk_idx, 9);
        lat = 0;
        while (!out_valid && lat < 60) begin
            if (garbage) begin
                in_valid = lat[0];
                in_data  = {$urandom, $urandom, $urandom, $urandom};
                chk({tag, " in_ready in ROUND"}, in_ready, 0);
            end
            stalled  = (stall_left > 0) && (rk_idx == 4'(stall_idx));
            rk_valid = !stalled;
            if (stalled) stall_left--;
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (stalled) chk({tag, " rk_idx held in stall"}, rk_idx, 128'(stall_idx));
        end
        in_valid = 1'b0;
        rk_valid = 1'b1;
        chk({tag, " latency"}, 128'(lat), 128'(exp_lat));
        chk({tag, " out_valid"}, out_valid, 1);
        chk({tag, " out_data"}, out_data, pt);
        chk({tag, " rk_idx in DONE"}, rk_idx, 0);
        for (int i = 0; i < ready_wait; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, " out_valid held"}, out_valid, 1);
            chk({tag, " out_data held"}, out_data, pt);
            chk({tag, " in_ready in DONE"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, " out_valid after handshake"}, out_valid, 0);
        chk({tag, " busy after handshake"}, busy, 0);
        chk({tag, " in_ready after handshake"}, in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; rk_valid = 1'b1; out_ready = 1'b0; key_sel = 1'b0;
        build_sbox();
        expand(0, KEY_A);
        expand(1, KEY_B);

        @(negedge clk);
        chk("in_ready during rst", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset rk_idx", rk_idx, 10);
        chk("reset in_ready", in_ready, 1);
        chk("reset out_data", out_data, 0);

        // in_valid with rk_valid low must not start a block
        in_valid = 1'b1; in_data = CT_A; rk_valid = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("no accept without rk_valid busy", busy, 0);
        chk("no accept without rk_valid in_ready", in_ready, 1);
        in_valid = 1'b0; rk_valid = 1'b1;

        run_block(CT_A, PT_A, 15, 0, 0, 10, 1'b0, "c1");
        key_sel = 1'b1;
        run_block(CT_B, PT_B, 15, 0, 5, 10, 1'b0, "fipsB");
        key_sel = 1'b0;
        run_block(CT_A, PT_A, 5, 3, 0, 13, 1'b0, "stall");

        // Reset in the middle of a block
        in_data = CT_A; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (rk_idx != 4'd4 && n < 20) begin @(posedge clk); @(negedge clk); n++; end
        chk("midrst reached rk_idx 4", rk_idx, 4);
        rst = 1'b1;
        #1;
        chk("midrst in_ready during rst", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst out_valid", out_valid, 0);
        chk("midrst busy", busy, 0);
        chk("midrst rk_idx", rk_idx, 10);
        chk("midrst in_ready", in_ready, 1);
        run_block(CT_A, PT_A, 15, 0, 0, 10, 1'b0, "post_rst");

        key_sel = 1'b1;
        run_block(CT_B, PT_B, 15, 0, 0, 10, 1'b1, "ignore");

        // Back-to-back with in_valid held high
        key_sel = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = CT_A; rk_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_data = CT_B;
        chk("b2b first busy", busy, 1);
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); @(negedge clk); n++; end
        chk("b2b first latency", 128'(n), 10);
        chk("b2b first out_data", out_data, PT_A);
        key_sel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b2b idle gap busy", busy, 0);
        chk("b2b idle gap in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b second accept busy", busy, 1);
        chk("b2b second accept rk_idx", rk_idx, 9);
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); @(negedge clk); n++; end
        chk("b2b second latency", 128'(n), 10);
        chk("b2b second out_data", out_data, PT_B);
        @(posedge clk);
        @(negedge clk);
        chk("b2b second drained", out_valid, 0);
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_dec_iter_ctrl.md
# aes_dec_iter_ctrl

- Iterative AES-128 decryption engine: one inverse round per clock over a single 128-bit state register.
- Sequences the existing InvMixColumns datapath together with InvShiftRows, InvSubBytes and AddRoundKey.
- Fetches round keys from an external key store by index.
- Sits between the ciphertext source (valid/ready) and the plaintext sink (valid/ready).

## Interface
Parameters: none (AES-128 only, Nr = 10 fixed).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  ciphertext block offered
- in_ready  out  1  block accepted when in_valid & in_ready
- in_data  in  128  ciphertext; bits [127:120] = s(0,0), column c = bits [127-32c -: 32], row 0 most significant within column
- rk_idx  out  4  round-key index requested, 0..10
- rk_in  in  128  round key for rk_idx, same byte order as in_data, valid same cycle
- rk_valid  in  1  rk_in usable this cycle; low stalls the engine
- out_valid  out  1  plaintext available
- out_ready  in  1  sink accepts when out_valid & out_ready
- out_data  out  128  plaintext, same byte order
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- FSM states: IDLE, ROUND, DONE. Round counter rnd is 4 bits.
- IDLE:
  - in_ready = 1, rk_idx = 10.
  - On in_valid & rk_valid: state <= in_data ^ rk_in, rnd <= 9, go to ROUND.
  - in_valid with rk_valid low: no accept; in_ready stays 1 but the transfer does not count. Source must hold in_data.
- ROUND:
  - rk_idx = rnd. When rk_valid is high, state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_in) for rnd 9..1.
  - For rnd = 0, state <= InvSubBytes(InvShiftRows(state)) ^ rk_in with no InvMixColumns, then go to DONE.
  - rnd decrements by 1 per advancing cycle.
  - rk_valid low: state and rnd hold, no advance.
- DONE:
  - out_valid = 1, out_data = state register, rk_idx = 0.
  - On out_ready, go to IDLE.
  - out_data is stable while out_valid is high and out_ready is low.
- Datapath:
  - InvShiftRows: row r is rotated right by r byte positions.
  - InvSubBytes: 16 parallel inverse S-box lookups (FIPS-197 table).
  - All XORs are bitwise over 128 bits.
- in_valid outside IDLE is ignored; in_data is not sampled.
- out_ready outside DONE is ignored.
- Out-of-range rnd cannot occur. If it does (encoding error), the FSM goes to IDLE.

## Timing
- Reset (any cycle, including mid-round): next cycle state = IDLE, rnd = 9, out_valid = 0, busy = 0, in_ready = 1, rk_idx = 10, state register = 0, out_data = 0. An in-flight block is discarded and is never output.
- in_ready is 0 during the cycle in which rst is high.
- Latency, no stalls: accept edge T; rounds complete on edges T+1..T+10; out_valid is high in the cycle after edge T+10 (10 cycles accept-to-valid).
- Each low-rk_valid cycle in ROUND adds exactly 1 cycle of latency.
- Throughput: DONE & out_ready at edge U gives IDLE at U+1. Earliest next accept is edge U+1, so the minimum is 12 cycles per block.
- rk_idx is a function of state and rnd only; it never depends combinationally on rk_valid or in_valid.
- busy = 1 from the cycle after accept until the cycle after the output handshake.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f (bench key-expansion model drives rk_in from rk_idx), rk_valid = 1, in_data = 69c4e0d86a7b0430d8cdb78070b4c55a, out_ready = 1 → out_data = 00112233445566778899aabbccddeeff, out_valid exactly 10 cycles after accept, asserted for 1 cycle.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, in_data = 3925841d02dc09fbdc118597196a0b32, out_ready low for 5 cycles after out_valid → out_data = 3243f6a8885a308d313198a2e0370734, held stable for all 6 cycles, in_ready = 0 throughout.
- Stall: C.1 vector with rk_valid low for 3 cycles while rk_idx = 5 → correct plaintext, latency 13 cycles, rk_idx stays 5 during the stall.
- Reset mid-operation: assert rst while rk_idx = 4 → next cycle out_valid = 0, busy = 0, rk_idx = 10, in_ready = 1. The following C.1 block decrypts correctly.
- Back-to-back: in_valid held high with C.1 then B ciphertexts, out_ready = 1 → second accept occurs 1 cycle after the first output handshake, and both plaintexts are correct and in order.
- Ignore while busy: toggle in_valid with garbage in_data during ROUND → no accept, result unaffected, in_ready = 0.
